// File: rtl/ysyx_25040101_core_seq_if.sv
// Fetch and data-memory valid/ready bus between the core sequencer (master)
// and the IFU/LSU bus ports (slave).
interface ysyx_25040101_core_seq_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_data,
        output lsu_req_valid,
        input  lsu_req_ready,
        input  lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_data,
        input  lsu_req_valid,
        output lsu_req_ready,
        output lsu_rsp_valid
    );
endinterface

// File: rtl/ysyx_25040101_core_seq.sv
// Multi-cycle NPC sequencer: fetch, execute, optional load/store, PC advance, halt on ebreak.
// Optional PERF_CNT_EN adds cycle and retired-instruction counters.
module ysyx_25040101_core_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_25040101_core_seq_if.master  bus,
    output logic [31:0]               inst_o,
    input  logic                      dec_rd_wen,
    input  logic                      dec_is_load,
    input  logic                      dec_is_store,
    input  logic                      dec_ebreak,
    input  logic [31:0]               next_pc_i,
    output logic [31:0]               pc_o,
    output logic                      rf_wen_o,
    output logic                      retire_o,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0]          cyc_cnt_o,
    output logic [CNT_W-1:0]          inst_cnt_o,
`endif
    output logic                      halt_o
);

    typedef enum logic [2:0] {
        F_REQ,
        F_WAIT,
        EXEC,
        M_REQ,
        M_WAIT,
        HALT
    } state_t;

    state_t state;

    // Request valids are registered alongside the state; ifu_req_valid comes out
    // of reset high because the reset state is F_REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= F_REQ;
            pc_o              <= RESET_PC;
            inst_o            <= '0;
            bus.ifu_req_valid <= 1'b1;
            bus.lsu_req_valid <= 1'b0;
            halt_o            <= 1'b0;
        end else begin
            case (state)
                F_REQ: begin
                    if (bus.ifu_req_ready) begin
                        state             <= F_WAIT;
                        bus.ifu_req_valid <= 1'b0;
                    end
                end
                F_WAIT: begin
                    if (bus.ifu_rsp_valid) begin
                        inst_o <= bus.ifu_rsp_data;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (dec_ebreak) begin
                        state  <= HALT;
                        halt_o <= 1'b1;
                    end else if (dec_is_load || dec_is_store) begin
                        state             <= M_REQ;
                        bus.lsu_req_valid <= 1'b1;
                    end else begin
                        pc_o              <= next_pc_i;
                        state             <= F_REQ;
                        bus.ifu_req_valid <= 1'b1;
                    end
                end
                M_REQ: begin
                    if (bus.lsu_req_ready) begin
                        state             <= M_WAIT;
                        bus.lsu_req_valid <= 1'b0;
                    end
                end
                M_WAIT: begin
                    if (bus.lsu_rsp_valid) begin
                        pc_o              <= next_pc_i;
                        state             <= F_REQ;
                        bus.ifu_req_valid <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state             <= F_REQ;
                    bus.ifu_req_valid <= 1'b1;
                    bus.lsu_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Strobes depend on decode of the IR held in EXEC, so they follow the state combinationally.
    always_comb begin
        rf_wen_o = 1'b0;
        retire_o = 1'b0;
        case (state)
            EXEC: begin
                if (dec_ebreak) begin
                    retire_o = 1'b1;
                end else if (!(dec_is_load || dec_is_store)) begin
                    retire_o = 1'b1;
                    rf_wen_o = dec_rd_wen;
                end
            end
            M_WAIT: begin
                if (bus.lsu_rsp_valid) begin
                    retire_o = 1'b1;
                    rf_wen_o = dec_is_load;
                end
            end
            default: ;
        endcase
    end

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_o  <= '0;
            inst_cnt_o <= '0;
        end else begin
            if (state != HALT) begin
                cyc_cnt_o <= cyc_cnt_o + CNT_ONE;
            end
            if (retire_o) begin
                inst_cnt_o <= inst_cnt_o + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25040101_core_seq.sv
// Randomized scoreboard bench for ysyx_25040101_core_seq: stimulus pushes expected
// retirements, a monitor pops and compares them whenever retire_o is seen.
module tb_ysyx_25040101_core_seq;

    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;
    localparam logic [6:0]  OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_LD   = 7'b0000011;
    localparam logic [6:0]  OP_ST   = 7'b0100011;
    localparam logic [6:0]  OP_LDST = 7'b0001011;  // decodes as load and store together
    localparam logic [6:0]  OP_EBL  = 7'b0101011;  // decodes as ebreak plus load/store/rd_wen

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25040101_core_seq_if bus();

    logic [31:0] inst_o, pc_o, next_pc_i;
    logic        dec_rd_wen, dec_is_load, dec_is_store, dec_ebreak;
    logic        rf_wen_o, retire_o, halt_o;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt_o, inst_cnt_o;
`endif

    ysyx_25040101_core_seq #(.RESET_PC(RST_PC), .CNT_W(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .inst_o       (inst_o),
        .dec_rd_wen   (dec_rd_wen),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_ebreak   (dec_ebreak),
        .next_pc_i    (next_pc_i),
        .pc_o         (pc_o),
        .rf_wen_o     (rf_wen_o),
        .retire_o     (retire_o),
`ifdef PERF_CNT_EN
        .cyc_cnt_o    (cyc_cnt_o),
        .inst_cnt_o   (inst_cnt_o),
`endif
        .halt_o       (halt_o)
    );

    // Bench-side decoder and next-PC datapath.
    logic [6:0] dop;
    always_comb begin
        dop          = inst_o[6:0];
        dec_ebreak   = (inst_o == EBREAK) || (dop == OP_EBL);
        dec_is_load  = (dop == OP_LD) || (dop == OP_LDST) || (dop == OP_EBL);
        dec_is_store = (dop == OP_ST) || (dop == OP_LDST) || (dop == OP_EBL);
        dec_rd_wen   = ((dop == OP_IMM) || (dop == OP_JAL) || (dop == OP_EBL)) && (inst_o[11:7] != 5'd0);
        if (dop == OP_BR)       next_pc_i = pc_o + {{20{inst_o[31]}}, inst_o[31:20]};
        else if (dop == OP_JAL) next_pc_i = {inst_o[31:12], 12'hFFC};
        else                    next_pc_i = pc_o + 32'd4;
    end

    typedef struct {
        logic [31:0] pc;
        logic        wen;
        logic        mem;
        logic        halt;
        logic [31:0] nxt;
    } exp_t;

    exp_t        exp_q[$];
    int          ret_cyc[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] model_pc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what an instruction at pc must do when it retires.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op;
        logic       rd_nz;
        op     = inst[6:0];
        rd_nz  = (inst[11:7] != 5'd0);
        e.pc   = pc;
        e.wen  = 1'b0;
        e.mem  = 1'b0;
        e.halt = 1'b0;
        e.nxt  = pc + 32'd4;
        if (inst == EBREAK || op == OP_EBL) begin
            e.halt = 1'b1;
        end else begin
            case (op)
                OP_IMM:        e.wen = rd_nz;
                OP_BR:         e.nxt = pc + {{20{inst[31]}}, inst[31:20]};
                OP_JAL: begin
                    e.wen = rd_nz;
                    e.nxt = {inst[31:12], 12'hFFC};
                end
                OP_LD, OP_LDST: begin
                    e.mem = 1'b1;
                    e.wen = 1'b1;
                end
                OP_ST:         e.mem = 1'b1;
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 7);
        case (k)
            0, 1:    return {r[31:7], OP_IMM};
            2:       return {r[31:7], OP_BR};
            3:       return ($urandom_range(0, 3) == 0) ? {20'hFFFFF, r[11:7], OP_JAL} : {r[31:7], OP_JAL};
            4, 5:    return {r[31:7], OP_LD};
            6:       return {r[31:7], OP_ST};
            default: return {r[31:7], OP_LDST};
        endcase
    endfunction

    // Monitor: samples one unit before each rising edge, well clear of stimulus changes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (retire_o === 1'b1) begin
                ret_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire_unexpected: retire at pc %h with empty scoreboard", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_pc", pc_o, e.pc);
                    chk("retire_rf_wen", {31'd0, rf_wen_o}, {31'd0, e.wen});
                end
            end else if (rf_wen_o !== 1'b0) begin
                chk("rf_wen_without_retire", {31'd0, rf_wen_o}, 32'd0);
            end
        end
    end

    // One instruction through the bus: fetch with given delays, then the LSU phase if needed.
    task automatic run_inst(input logic [31:0] inst, input int fr, input int fs,
                            input int mr, input int ms, input bit junk, input bit abort_mem);
        exp_t e;
        int   n;
        e = model(inst, model_pc);
        n = 0;
        while (bus.ifu_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ifu_req_timeout: ifu_req_valid=%b expected 1 within 50 cycles", bus.ifu_req_valid);
        end
        chk("fetch_pc", pc_o, model_pc);
        repeat (fr) begin
            @(negedge clk);
            chk("ifu_valid_held", {31'd0, bus.ifu_req_valid}, 32'd1);
            chk("pc_stable", pc_o, model_pc);
        end
        bus.ifu_req_ready = 1'b1;
        if (junk) begin
            bus.ifu_rsp_valid = 1'b1;
            bus.ifu_rsp_data  = EBREAK;
        end
        @(negedge clk);
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        chk("ifu_valid_drop", {31'd0, bus.ifu_req_valid}, 32'd0);
        repeat (fs) @(negedge clk);
        exp_q.push_back(e);
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = inst;
        @(negedge clk);
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_data  = $urandom();
        chk("inst_latched", inst_o, inst);
        if (e.mem) begin
            n = 0;
            while (bus.lsu_req_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL lsu_req_timeout: lsu_req_valid=%b expected 1 within 50 cycles", bus.lsu_req_valid);
            end
            chk("no_fetch_in_m_req", {31'd0, bus.ifu_req_valid}, 32'd0);
            repeat (mr) begin
                @(negedge clk);
                chk("lsu_valid_held", {31'd0, bus.lsu_req_valid}, 32'd1);
            end
            bus.lsu_req_ready = 1'b1;
            if (junk) bus.lsu_rsp_valid = 1'b1;
            @(negedge clk);
            bus.lsu_req_ready = 1'b0;
            bus.lsu_rsp_valid = 1'b0;
            chk("lsu_valid_drop", {31'd0, bus.lsu_req_valid}, 32'd0);
            chk("no_fetch_in_m_wait", {31'd0, bus.ifu_req_valid}, 32'd0);
            if (abort_mem) begin
                #2 rst = 1'b1;
                #1;
                chk("async_rst_pc", pc_o, RST_PC);
                chk("async_rst_inst", inst_o, 32'd0);
                chk("async_rst_lsu_valid", {31'd0, bus.lsu_req_valid}, 32'd0);
                chk("async_rst_halt", {31'd0, halt_o}, 32'd0);
                chk("async_rst_retire", {31'd0, retire_o}, 32'd0);
                return;
            end
            repeat (ms) @(negedge clk);
            bus.lsu_rsp_valid = 1'b1;
            @(negedge clk);
            bus.lsu_rsp_valid = 1'b0;
        end
        if (!e.halt) model_pc = e.nxt;
    endtask

    task automatic check_halted(input logic [31:0] hpc);
        @(negedge clk);
        chk("halt_set", {31'd0, halt_o}, 32'd1);
        chk("halt_pc", pc_o, hpc);
        repeat (5) begin
            @(negedge clk);
            chk("halt_no_ifu_req", {31'd0, bus.ifu_req_valid}, 32'd0);
            chk("halt_no_lsu_req", {31'd0, bus.lsu_req_valid}, 32'd0);
            chk("halt_sticky", {31'd0, halt_o}, 32'd1);
            chk("halt_pc_hold", pc_o, hpc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        model_pc = RST_PC;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] addi(input int rd);
        logic [4:0] r5;
        r5 = rd[4:0];
        return {12'd1, 5'd0, 3'b000, r5, OP_IMM};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_data  = '0;
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        model_pc = RST_PC;
        repeat (3) @(negedge clk);
        chk("reset_pc", pc_o, RST_PC);
        chk("reset_inst", inst_o, 32'd0);
        chk("reset_lsu_valid", {31'd0, bus.lsu_req_valid}, 32'd0);
        chk("reset_rf_wen", {31'd0, rf_wen_o}, 32'd0);
        chk("reset_retire", {31'd0, retire_o}, 32'd0);
        chk("reset_halt", {31'd0, halt_o}, 32'd0);
`ifdef PERF_CNT_EN
        chk("reset_cyc_cnt", cyc_cnt_o, 32'd0);
        chk("reset_inst_cnt", inst_cnt_o, 32'd0);
`endif
        rst = 1'b0;
        ret_cyc.delete();

        // Zero-wait addi stream: one retirement every three cycles.
        for (int i = 0; i < 3; i++) run_inst(addi(i + 1), 0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("retire_count_3", ret_cyc.size(), 32'd3);
        if (ret_cyc.size() >= 3) begin
            chk("retire_gap_1", ret_cyc[1] - ret_cyc[0], 32'd3);
            chk("retire_gap_2", ret_cyc[2] - ret_cyc[1], 32'd3);
        end
        chk("pc_after_3", pc_o, RST_PC + 32'd12);

        run_inst(addi(5), 4, 0, 0, 0, 1'b0, 1'b0);
        run_inst({12'h010, 5'd2, 3'b010, 5'd7, OP_LD}, 0, 0, 2, 3, 1'b0, 1'b0);
        run_inst({7'd0, 5'd7, 5'd2, 3'b010, 5'd4, OP_ST}, 0, 1, 1, 0, 1'b1, 1'b0);
        run_inst({25'h0ABCDE, OP_LDST}, 0, 0, 0, 0, 1'b0, 1'b0);
        run_inst({12'd1, 5'd0, 3'b000, 5'd0, OP_IMM}, 1, 2, 0, 0, 1'b1, 1'b0);
        run_inst({12'hFF8, 13'd0, OP_BR}, 0, 0, 0, 0, 1'b0, 1'b0);
        // PC wrap: jump to FFFF_FFFC, the next fetch must be at 0.
        run_inst({20'hFFFFF, 5'd1, OP_JAL}, 0, 0, 0, 0, 1'b0, 1'b0);
        run_inst(addi(3), 0, 0, 0, 0, 1'b0, 1'b0);
        run_inst(addi(4), 0, 0, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            run_inst(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Reset during M_WAIT, then 3 addi + ebreak from RESET_PC.
        run_inst({12'h020, 5'd1, 3'b010, 5'd9, OP_LD}, 0, 0, 1, 0, 1'b0, 1'b1);
        exp_q.delete();
        model_pc = RST_PC;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) run_inst(addi(i + 1), 0, 0, 0, 0, 1'b0, 1'b0);
        run_inst({25'h0000C8, OP_EBL}, 0, 0, 0, 0, 1'b0, 1'b0);
        check_halted(RST_PC + 32'd12);
`ifdef PERF_CNT_EN
        chk("perf_inst_cnt", inst_cnt_o, 32'd4);
        chk("perf_cyc_cnt_frozen", cyc_cnt_o, 32'd12);
`endif

        do_reset();
        for (int i = 0; i < 2; i++) run_inst(addi(i + 6), 0, 0, 0, 0, 1'b0, 1'b0);
        run_inst(EBREAK, 0, 0, 0, 0, 1'b0, 1'b0);
        check_halted(RST_PC + 32'd8);

        @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
